// File: rtl/parity_frame_pkg.sv
// Shared constants for the odd-parity serial frame transmitter: state encoding,
// line levels of the framing bits and a width helper.
package parity_frame_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Bits needed to count 0..n-1; never less than one so counters stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/odd_parity_calc.sv
// Combinational odd-parity bit: total ones in {data, parity} is always odd.
module odd_parity_calc #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  assign parity_o = ~^data_i;

endmodule

// File: rtl/odd_parity_frame_tx.sv
// Serial frame transmitter: start, DATA_W data bits LSB first, odd parity, stop.
// Optional macro PARITY_ERR_INJECT_EN adds err_inject to corrupt one frame's parity bit.
module odd_parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PARITY_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done,
  output logic              parity_out
);

  localparam int CW = clog2(BIT_CYCLES);
  localparam int IW = clog2(DATA_W);

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              inj_q, inj_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              par_calc, accept, bit_end;

  odd_parity_calc #(.DATA_W(DATA_W)) u_parity (
    .data_i   (in_data),
    .parity_o (par_calc)
  );

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;

  generate
    if (BIT_CYCLES == 1) begin : g_single
      assign bit_end = 1'b1;
    end else begin : g_multi
      assign bit_end = (cnt_q == CW'(BIT_CYCLES - 1));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    inj_d   = inj_q;
    done_d  = 1'b0;
    cnt_d   = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          shreg_d = in_data;
          par_d   = par_calc;
`ifdef PARITY_ERR_INJECT_EN
          inj_d   = err_inject;
`else
          inj_d   = 1'b0;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IW'(DATA_W - 1)) begin
            state_d = S_PARITY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx_out comes straight from a flop.
  always_comb begin
    case (state_d)
      S_START:  tx_d = START_BIT;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d ^ inj_d;
      S_STOP:   tx_d = STOP_BIT;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      inj_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      inj_q   <= inj_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Payload needs no reset: it is always loaded on accept before it is shifted out.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign parity_out = par_q;

endmodule

// File: tb/tb_odd_parity_frame_tx.sv
// Directed bench for odd_parity_frame_tx (DATA_W=4, BIT_CYCLES=2); the
// err_inject scenario uses a second BIT_CYCLES=1 instance when PARITY_ERR_INJECT_EN is set.
module tb_odd_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready, tx_out, busy, frame_done, parity_out;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

`ifdef PARITY_ERR_INJECT_EN
  logic       err0;
  logic [3:0] in_data1;
  logic       in_valid1, err1;
  logic       in_ready1, tx_out1, busy1, frame_done1, parity_out1;

  odd_parity_frame_tx #(.DATA_W(4), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .err_inject(err1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx_out(tx_out1), .busy(busy1), .frame_done(frame_done1),
    .parity_out(parity_out1)
  );
`endif

  odd_parity_frame_tx #(.DATA_W(4), .BIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
`ifdef PARITY_ERR_INJECT_EN
    .err_inject(err0),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .tx_out(tx_out),
    .busy(busy), .frame_done(frame_done), .parity_out(parity_out)
  );

  // Expected line level k clocks after the first START cycle.
  function automatic logic exp_bit(input logic [3:0] d, input logic p, input int k, input int bc);
    int b;
    b = k / bc;
    if (b == 0) return 1'b0;
    if (b <= 4) return d[b-1];
    if (b == 5) return p;
    return 1'b1;
  endfunction

  task automatic drive_accept(input logic [3:0] d);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 4'b0000;
`ifdef PARITY_ERR_INJECT_EN
    err0 = 1'b0; err1 = 1'b0; in_valid1 = 1'b0; in_data1 = 4'b0000;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || parity_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b par=%b, want 1 0 0 0",
               tx_out, busy, frame_done, parity_out);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_single_frame(input string name, input logic [3:0] d, input logic p);
    drive_accept(d);
    checks++;
    if (parity_out !== p) begin
      errors++;
      $display("FAIL %s_parity_out: got %b want %b", name, parity_out, p);
    end
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tx_out !== exp_bit(d, p, k, 2) || busy !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL %s_bit%0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                 name, k, tx_out, busy, frame_done, exp_bit(d, p, k, 2));
      end
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || in_ready !== 1'b1 || tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done=%b ready=%b tx=%b busy=%b, want 1 1 1 0",
               name, frame_done, in_ready, tx_out, busy);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b want 0", name, frame_done);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_data = 4'b0001; in_valid = 1'b1;
    @(negedge clk);
    in_data = 4'b0011;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tx_out !== exp_bit(4'b0001, 1'b0, k, 2) || parity_out !== 1'b0) begin
        errors++;
        $display("FAIL b2b_f1_bit%0d: tx=%b par=%b, want tx=%b par=0",
                 k, tx_out, parity_out, exp_bit(4'b0001, 1'b0, k, 2));
      end
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || in_ready !== 1'b1 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: done=%b ready=%b tx=%b, want 1 1 1", frame_done, in_ready, tx_out);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tx_out !== exp_bit(4'b0011, 1'b1, k, 2) || parity_out !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_f2_bit%0d: tx=%b par=%b done=%b, want tx=%b par=1 done=0",
                 k, tx_out, parity_out, frame_done, exp_bit(4'b0011, 1'b1, k, 2));
      end
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_f2_done: done=%b want 1", frame_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    bit bad;
    drive_accept(4'b1010);
    repeat (5) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: tx=%b busy=%b want 1 1 (data bit 1 of 1010)", tx_out, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: tx=%b busy=%b done=%b want 1 0 0", tx_out, busy, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst_quiet: activity after abort, want idle line and no frame_done");
    end
    test_single_frame("after_rst", 4'b0001, 1'b0);
  endtask

  task automatic test_ignore_busy();
    bit bad;
    drive_accept(4'b0111);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (tx_out !== exp_bit(4'b0111, 1'b0, k, 2)) begin
        errors++;
        $display("FAIL busy_bit%0d: tx=%b want %b", k, tx_out, exp_bit(4'b0111, 1'b0, k, 2));
      end
      if (k == 3) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready: in_ready=%b want 0", in_ready);
        end
        in_data = 4'b1111; in_valid = 1'b1;
      end
      if (k == 4) in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || parity_out !== 1'b0) begin
      errors++;
      $display("FAIL busy_done: done=%b par=%b want 1 0", frame_done, parity_out);
    end
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_out !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL busy_no_extra: a frame followed the ignored word");
    end
  endtask

`ifdef PARITY_ERR_INJECT_EN
  task automatic test_err_inject();
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      in_data1 = 4'b0000; in_valid1 = 1'b1; err1 = (f == 0);
      @(negedge clk);
      in_valid1 = 1'b0; err1 = 1'b0;
      checks++;
      if (parity_out1 !== 1'b1) begin
        errors++;
        $display("FAIL inj%0d_parity_out: got %b want 1", f, parity_out1);
      end
      for (int k = 0; k < 7; k++) begin
        if (k > 0) @(negedge clk);
        checks++;
        if (tx_out1 !== exp_bit(4'b0000, (f == 0) ? 1'b0 : 1'b1, k, 1)) begin
          errors++;
          $display("FAIL inj%0d_bit%0d: tx=%b want %b", f, k, tx_out1,
                   exp_bit(4'b0000, (f == 0) ? 1'b0 : 1'b1, k, 1));
        end
      end
      @(negedge clk);
      checks++;
      if (frame_done1 !== 1'b1) begin
        errors++;
        $display("FAIL inj%0d_done: done=%b want 1", f, frame_done1);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame("frame_0000", 4'b0000, 1'b1);
    test_single_frame("frame_0111", 4'b0111, 1'b0);
    test_back_to_back();
    test_reset_mid_frame();
    test_ignore_busy();
`ifdef PARITY_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
